// File: rtl/tl_coupler_arbiter.sv
// ----------------------------------------------------------------------------
// tl_coupler_arbiter
// Two-requester TileLink A-channel arbiter in front of a bus-crossing coupler,
// plus the matching D-channel response router.
//
// A side: the granted requester passes straight through with no added latency.
// Its source id is extended with the grant bit as the new MSB. A round-robin
// pointer picks between simultaneous requesters. Multi-beat Put bursts lock the
// grant until their final beat.
// D side: purely combinational. source[5] selects the requester and
// source[4:0] is handed back to it.
//
// Ports
//   clock, reset           single clock, asynchronous active-high reset
//   inN_a_*  (N=0,1)       requester A channels (valid/ready + payload)
//   inN_d_*  (N=0,1)       requester D channels (valid/ready + payload)
//   out_a_*                arbitrated A channel toward the coupler (source[6])
//   out_d_*                D channel from the coupler (source[6])
//   perf_grant0/1          completed-message counters, saturating
//                          (present only with TL_COUPLER_ARB_PERF_EN defined)
//
// Optional feature macro: TL_COUPLER_ARB_PERF_EN
// ----------------------------------------------------------------------------
module tl_coupler_arbiter #(
    parameter int LG_BEAT     = 3,
    parameter int LG_MAX_SIZE = 6
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in0_a_valid,
    output logic        in0_a_ready,
    input  logic [2:0]  in0_a_bits_opcode,
    input  logic [2:0]  in0_a_bits_param,
    input  logic [3:0]  in0_a_bits_size,
    input  logic [4:0]  in0_a_bits_source,
    input  logic [28:0] in0_a_bits_address,
    input  logic [7:0]  in0_a_bits_mask,
    input  logic [63:0] in0_a_bits_data,
    input  logic        in0_a_bits_corrupt,

    input  logic        in1_a_valid,
    output logic        in1_a_ready,
    input  logic [2:0]  in1_a_bits_opcode,
    input  logic [2:0]  in1_a_bits_param,
    input  logic [3:0]  in1_a_bits_size,
    input  logic [4:0]  in1_a_bits_source,
    input  logic [28:0] in1_a_bits_address,
    input  logic [7:0]  in1_a_bits_mask,
    input  logic [63:0] in1_a_bits_data,
    input  logic        in1_a_bits_corrupt,

    input  logic        in0_d_ready,
    output logic        in0_d_valid,
    output logic [2:0]  in0_d_bits_opcode,
    output logic [1:0]  in0_d_bits_param,
    output logic [3:0]  in0_d_bits_size,
    output logic [4:0]  in0_d_bits_source,
    output logic        in0_d_bits_sink,
    output logic        in0_d_bits_denied,
    output logic [63:0] in0_d_bits_data,
    output logic        in0_d_bits_corrupt,

    input  logic        in1_d_ready,
    output logic        in1_d_valid,
    output logic [2:0]  in1_d_bits_opcode,
    output logic [1:0]  in1_d_bits_param,
    output logic [3:0]  in1_d_bits_size,
    output logic [4:0]  in1_d_bits_source,
    output logic        in1_d_bits_sink,
    output logic        in1_d_bits_denied,
    output logic [63:0] in1_d_bits_data,
    output logic        in1_d_bits_corrupt,

    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [2:0]  out_a_bits_opcode,
    output logic [2:0]  out_a_bits_param,
    output logic [3:0]  out_a_bits_size,
    output logic [5:0]  out_a_bits_source,
    output logic [28:0] out_a_bits_address,
    output logic [7:0]  out_a_bits_mask,
    output logic [63:0] out_a_bits_data,
    output logic        out_a_bits_corrupt,

    input  logic        out_d_valid,
    output logic        out_d_ready,
    input  logic [2:0]  out_d_bits_opcode,
    input  logic [1:0]  out_d_bits_param,
    input  logic [3:0]  out_d_bits_size,
    input  logic [5:0]  out_d_bits_source,
    input  logic        out_d_bits_sink,
    input  logic        out_d_bits_denied,
    input  logic [63:0] out_d_bits_data,
    input  logic        out_d_bits_corrupt
`ifdef TL_COUPLER_ARB_PERF_EN
    ,
    output logic [31:0] perf_grant0,
    output logic [31:0] perf_grant1
`endif
);

    // Remaining-beats counter width: enough for (max beats - 1).
    localparam int CNT_W = (LG_MAX_SIZE - LG_BEAT > 0) ? (LG_MAX_SIZE - LG_BEAT) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;       // beats still to come in the locked burst
    logic             rr;        // preferred requester on a tie
    logic             lock_gnt;  // owner of the burst in progress
    logic             grant;

    // ---------------------------------------------------------------- grant
    always_comb begin
        grant = rr;
        if (state == LOCK)                  grant = lock_gnt;
        else if (in0_a_valid && in1_a_valid) grant = rr;
        else if (in1_a_valid)               grant = 1'b1;
        else if (in0_a_valid)               grant = 1'b0;
    end

    // ---------------------------------------------------------------- A mux
    assign out_a_bits_opcode  = grant ? in1_a_bits_opcode  : in0_a_bits_opcode;
    assign out_a_bits_param   = grant ? in1_a_bits_param   : in0_a_bits_param;
    assign out_a_bits_size    = grant ? in1_a_bits_size    : in0_a_bits_size;
    assign out_a_bits_source  = {grant, grant ? in1_a_bits_source : in0_a_bits_source};
    assign out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
    assign out_a_bits_mask    = grant ? in1_a_bits_mask    : in0_a_bits_mask;
    assign out_a_bits_data    = grant ? in1_a_bits_data    : in0_a_bits_data;
    assign out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;

    // Handshake is gated by reset so nothing can fire while it is held.
    assign out_a_valid = !reset && (grant ? in1_a_valid : in0_a_valid);
    assign in0_a_ready = !reset && !grant && out_a_ready;
    assign in1_a_ready = !reset &&  grant && out_a_ready;

    logic a_fire;
    assign a_fire = out_a_valid && out_a_ready;

    // ---------------------------------------------------------------- beats
    // Only PutFull/PutPartial larger than one beat are bursts. Sizes beyond
    // the counter range shift the one-hot out and clamp to the maximum count.
    logic             is_put;
    logic             multi;
    logic [3:0]       lg_beats;
    logic [CNT_W:0]   one_hot;
    logic [CNT_W-1:0] beats_m1;

    assign is_put   = (out_a_bits_opcode == 3'd0) || (out_a_bits_opcode == 3'd1);
    assign multi    = is_put && (out_a_bits_size > 4'(LG_BEAT));
    assign lg_beats = out_a_bits_size - 4'(LG_BEAT);
    assign one_hot  = {{CNT_W{1'b0}}, 1'b1} << lg_beats;
    assign beats_m1 = CNT_W'(one_hot - 1'b1);

    logic msg_done;
    assign msg_done = a_fire && ((state == IDLE) ? !multi : (cnt == CNT_W'(1)));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rr       <= 1'b0;
            lock_gnt <= 1'b0;
        end else if (a_fire) begin
            if (state == IDLE) begin
                if (multi) begin
                    state    <= LOCK;
                    cnt      <= beats_m1;
                    lock_gnt <= grant;
                end else begin
                    rr <= ~grant;
                end
            end else if (cnt == CNT_W'(1)) begin
                state <= IDLE;
                cnt   <= '0;
                rr    <= ~grant;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef TL_COUPLER_ARB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
        end else if (msg_done) begin
            if (!grant && perf_grant0 != '1) perf_grant0 <= perf_grant0 + 1'b1;
            if ( grant && perf_grant1 != '1) perf_grant1 <= perf_grant1 + 1'b1;
        end
    end
`endif

    // ---------------------------------------------------------------- D route
    logic d_sel;
    assign d_sel = out_d_bits_source[5];

    assign in0_d_valid = out_d_valid && !d_sel;
    assign in1_d_valid = out_d_valid &&  d_sel;
    assign out_d_ready = d_sel ? in1_d_ready : in0_d_ready;

    assign in0_d_bits_opcode  = out_d_bits_opcode;
    assign in0_d_bits_param   = out_d_bits_param;
    assign in0_d_bits_size    = out_d_bits_size;
    assign in0_d_bits_source  = out_d_bits_source[4:0];
    assign in0_d_bits_sink    = out_d_bits_sink;
    assign in0_d_bits_denied  = out_d_bits_denied;
    assign in0_d_bits_data    = out_d_bits_data;
    assign in0_d_bits_corrupt = out_d_bits_corrupt;

    assign in1_d_bits_opcode  = out_d_bits_opcode;
    assign in1_d_bits_param   = out_d_bits_param;
    assign in1_d_bits_size    = out_d_bits_size;
    assign in1_d_bits_source  = out_d_bits_source[4:0];
    assign in1_d_bits_sink    = out_d_bits_sink;
    assign in1_d_bits_denied  = out_d_bits_denied;
    assign in1_d_bits_data    = out_d_bits_data;
    assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: doc/tl_coupler_arbiter.md
TL_COUPLER_ARBITER -- requirements
Module: tl_coupler_arbiter

Interface
REQ-001 SHALL have parameter LG_BEAT, default 3, meaning log2 of the A/D beat size in bytes (64-bit bus).
REQ-002 SHALL have parameter LG_MAX_SIZE, default 6, meaning log2 of the largest transfer in bytes (max 8 beats).
REQ-003 SHALL have port clock, input, 1, the single clock for all state.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports inN_a_valid (input, 1) and inN_a_ready (output, 1), for N=0,1, the requester A handshake.
REQ-006 SHALL have inputs inN_a_bits_opcode[3], param[3], size[4], source[5], address[29], mask[8], data[64] and corrupt[1], for N=0,1, the requester A payload.
REQ-007 SHALL have ports inN_d_ready (input, 1) and inN_d_valid (output, 1), for N=0,1, the requester D handshake.
REQ-008 SHALL have outputs inN_d_bits_opcode[3], param[2], size[4], source[5], sink[1], denied[1], data[64] and corrupt[1], for N=0,1, the requester D payload.
REQ-009 SHALL have ports out_a_valid (output, 1) and out_a_ready (input, 1), plus out_a_bits_* outputs with the REQ-006 widths except source[6], toward the bus-crossing coupler.
REQ-010 SHALL have ports out_d_valid (input, 1) and out_d_ready (output, 1), plus out_d_bits_* inputs with the REQ-008 widths except source[6], from the coupler.

Function
REQ-011 SHALL set out_a_bits_source = {grant, inN_a_bits_source}; all other A fields SHALL pass through from the granted input with zero added latency.
REQ-012 SHALL assert out_a_valid = inG_a_valid and inG_a_ready = out_a_ready for the granted input G only; the non-granted input ready SHALL be 0.
REQ-013 SHALL use a two-state FSM: IDLE, where grant is chosen combinationally, and LOCK, where grant is held.
REQ-014 SHALL, in IDLE, grant the sole valid requester; on simultaneous valids it SHALL grant the requester not served last (rr pointer, reset value 0, so in0 wins first).
REQ-015 SHALL treat the beat count as 2^(size-LG_BEAT) when opcode is PutFull(0) or PutPartial(1) and size > LG_BEAT, and 1 otherwise.
REQ-016 SHALL, on the first A fire of a multi-beat message, enter LOCK and load the remaining-beats counter with beats-1 (3 bits).
REQ-017 SHALL, in LOCK, decrement the counter per A fire and return to IDLE on the fire with counter==1; the other requester SHALL never be granted mid-burst.
REQ-018 SHALL update the rr pointer to !grant on the last beat of every message (single-beat fire in IDLE, or final beat in LOCK).
REQ-019 SHALL not change state, counter or pointer on cycles with valid && !ready; the A payload SHALL remain stable from the chosen input.
REQ-020 SHALL route D responses by out_d_bits_source[5]: inN_d_valid = out_d_valid && src[5]==N; inN_d_bits_source = src[4:0]; other D fields broadcast.
REQ-021 SHALL drive out_d_ready = in{src[5]}_d_ready; D routing SHALL be purely combinational and independent of A arbitration.

Reset
REQ-022 SHALL, on reset assertion (asynchronous, including mid-burst), force FSM=IDLE, counter=0, rr pointer=0, and perf counters=0.
REQ-023 SHALL hold out_a_valid=0 and inN_a_ready=0 while reset is high; D routing outputs SHALL follow inputs.

Configuration
REQ-024 SHALL, with TL_COUPLER_ARB_PERF_EN defined, add outputs perf_grant0[32] and perf_grant1[32], which count completed messages per requester and saturate at 0xFFFFFFFF.
REQ-025 SHALL, without TL_COUPLER_ARB_PERF_EN, omit those ports and counters entirely, with all other behaviour identical.

Verification
REQ-026 SHALL cover: both in0 and in1 issue a single-beat Get after reset with ready=1 -> in0 fires at cycle 0, in1 at cycle 1, out source = 0x0X then 0x2X.
REQ-027 SHALL cover: in0 issues a PutFull of size 6 while in1 issues a Get concurrently -> 8 consecutive in0 beats, then the in1 Get, with in1_a_ready=0 throughout.
REQ-028 SHALL cover: a size-5 Put with out_a_ready toggling 1/0 -> exactly 4 fires, LOCK held across stalls, payload stable during stalls.
REQ-029 SHALL cover: out_d response with source 0x25 -> in1_d_valid=1, in1_d_bits_source=5, in0_d_valid=0, out_d_ready=in1_d_ready.
REQ-030 SHALL cover: reset asserted after beat 3 of an 8-beat burst -> next cycle IDLE, out_a_valid=0, and the following grant goes to in0.
REQ-031 SHALL cover: with PERF_EN defined, 3 in0 messages and 2 in1 messages -> perf_grant0=3, perf_grant1=2.
